fetch_pc_unit: RTL and testbench

- Instruction-fetch and next-PC stage that feeds the main control decoder and consumes its branch/jump flags.
- Owns the PC register and runs a req/ack handshake to instruction memory.
- Holds the fetched word in an instruction register until decode accepts it.
- On accept, resolves beq/bne/bgtz/blez/bltz/bgez/j/jal from the decoder flags plus register operands, and produces the jal link address. No delay slot.

---
 rtl/fetch_pc_unit_pkg.sv | 15 +
 rtl/next_pc_calc.sv | 56 +++++
 rtl/fetch_pc_unit.sv | 111 +++++++++++
 tb/tb_fetch_pc_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared state encoding, opcodes and reset PC for the fetch/next-PC stage
package fetch_pc_unit_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_REGIMM = 6'b000001;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC resolution for jumps and conditional branches
module next_pc_calc
    import fetch_pc_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        branchNotEqual,
    input  logic        jump,
    input  logic        jumpAndLink,
    input  logic        branchGreaterThanZero,
    input  logic        branchLessThanZero,
    input  logic        branchLessThanEqualToZero,
    input  logic        branchGreaterThanEqualToZero,
    input  logic        alu_zero,
    input  logic [31:0] rs_value,
    output logic [31:0] next_pc,
    output logic        taken
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] jump_target;
    logic        rs_neg;
    logic        rs_zero;
    logic        regimm_taken;

    // The opcode field is decoded upstream; only the flags reach this block.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instr[31:26];

    // Jump beats any branch; branch flags OR together; fall through to pc+4.
    always_comb begin
        pc_plus4     = pc + 32'd4;
        br_offset    = {{14{instr[15]}}, instr[15:0], 2'b00};
        jump_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
        rs_neg       = rs_value[31];
        rs_zero      = (rs_value == 32'd0);
        // bltz and bgez share REGIMM, so the rt[0] bit picks the sense.
        regimm_taken = (branchLessThanZero | branchGreaterThanEqualToZero)
                     & (instr[16] ? ~rs_neg : rs_neg);
        taken        = (branch & alu_zero)
                     | (branchNotEqual & ~alu_zero)
                     | (branchGreaterThanZero & ~rs_neg & ~rs_zero)
                     | (branchLessThanEqualToZero & (rs_neg | rs_zero))
                     | regimm_taken;
        if (jump | jumpAndLink) begin
            next_pc = jump_target;
        end else if (taken) begin
            next_pc = pc_plus4 + br_offset;
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register, imem req/ack fetch, instruction hold and accept
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_out,
    output logic             instr_valid,
    input  logic             decode_ready,
    output logic [31:0]      pc_out,
    input  logic             branch,
    input  logic             branchNotEqual,
    input  logic             jump,
    input  logic             jumpAndLink,
    input  logic             branchGreaterThanZero,
    input  logic             branchLessThanZero,
    input  logic             branchLessThanEqualToZero,
    input  logic             branchGreaterThanEqualToZero,
    input  logic             alu_zero,
    input  logic [31:0]      rs_value,
    output logic             link_we,
    output logic [31:0]      link_addr,
    output logic [CNT_W-1:0] retired
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         fetch_ack;
    logic         accept;
    // taken is only observed when next_pc_calc is exercised on its own.
    logic         unused_taken;

    // An ack only counts while a request is actually out, so the idle
    // first cycle after reset cannot capture stray data.
    assign fetch_ack = (state == FETCH) && imem_req && imem_ack;
    assign accept    = (state == HOLD) && decode_ready;
    assign imem_addr = pc;
    assign pc_out    = pc;

    next_pc_calc u_next_pc_calc (
        .pc                           (pc),
        .instr                        (instr_out),
        .branch                       (branch),
        .branchNotEqual               (branchNotEqual),
        .jump                         (jump),
        .jumpAndLink                  (jumpAndLink),
        .branchGreaterThanZero        (branchGreaterThanZero),
        .branchLessThanZero           (branchLessThanZero),
        .branchLessThanEqualToZero    (branchLessThanEqualToZero),
        .branchGreaterThanEqualToZero (branchGreaterThanEqualToZero),
        .alu_zero                     (alu_zero),
        .rs_value                     (rs_value),
        .next_pc                      (next_pc),
        .taken                        (unused_taken)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: FETCH until memory acks, HOLD until decode accepts.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (fetch_ack) state_nxt = HOLD;
            HOLD:    if (decode_ready) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Datapath: request line, instruction capture, PC update, link pulse, retire count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr_out   <= 32'd0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            link_we     <= 1'b0;
            link_addr   <= 32'd0;
            retired     <= '0;
        end else begin
            imem_req <= (state_nxt == FETCH);
            link_we  <= accept & jumpAndLink;
            if (fetch_ack) begin
                instr_out   <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (accept) begin
                pc          <= next_pc;
                retired     <= retired + CNT_W'(1);
                instr_valid <= 1'b0;
                link_addr   <= pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;

    localparam logic [7:0] F_NONE   = 8'h00;
    localparam logic [7:0] F_BEQ    = 8'h80;
    localparam logic [7:0] F_BNE    = 8'h40;
    localparam logic [7:0] F_J      = 8'h20;
    localparam logic [7:0] F_JAL    = 8'h10;
    localparam logic [7:0] F_BGTZ   = 8'h08;
    localparam logic [7:0] F_BLEZ   = 8'h02;
    localparam logic [7:0] F_REGIMM = 8'h05;

    localparam logic [31:0] ADDI = 32'h2008_0005;
    localparam logic [31:0] J80  = 32'h0800_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        decode_ready = 1'b0;
    logic [31:0] pc_out;
    logic [7:0]  flags = 8'd0;
    logic        alu_zero = 1'b0;
    logic [31:0] rs_value = 32'd0;
    logic        link_we;
    logic [31:0] link_addr;
    logic [31:0] retired;

    int          vectors = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_retired = 32'd0;
    logic [31:0] walk_pc;

    fetch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .imem_req                     (imem_req),
        .imem_addr                    (imem_addr),
        .imem_ack                     (imem_ack),
        .imem_rdata                   (imem_rdata),
        .instr_out                    (instr_out),
        .instr_valid                  (instr_valid),
        .decode_ready                 (decode_ready),
        .pc_out                       (pc_out),
        .branch                       (flags[7]),
        .branchNotEqual               (flags[6]),
        .jump                         (flags[5]),
        .jumpAndLink                  (flags[4]),
        .branchGreaterThanZero        (flags[3]),
        .branchLessThanZero           (flags[2]),
        .branchLessThanEqualToZero    (flags[1]),
        .branchGreaterThanEqualToZero (flags[0]),
        .alu_zero                     (alu_zero),
        .rs_value                     (rs_value),
        .link_we                      (link_we),
        .link_addr                    (link_addr),
        .retired                      (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction: wait for the request, ack after 'delay' cycles,
    // stall decode for 'stall' cycles, then accept and expect exp_next.
    task automatic step(input logic [31:0] instr, input logic [7:0] f, input logic az,
                        input logic [31:0] rs, input int delay, input int stall,
                        input logic [31:0] exp_next);
        logic [31:0] exp_pc;
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            exp_pc = 32'hxxxx_xxxx;
        end else begin
            exp_pc = exp_q.pop_front();
        end
        check("imem_addr", imem_addr, exp_pc);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("req_hold", {31'd0, imem_req}, 32'd1);
            check("addr_hold", imem_addr, exp_pc);
            check("valid_low", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        check("valid", {31'd0, instr_valid}, 32'd1);
        check("instr_out", instr_out, instr);
        check("pc_out", pc_out, exp_pc);
        check("req_low", {31'd0, imem_req}, 32'd0);
        flags    = f;
        alu_zero = az;
        rs_value = rs;
        // Acks during HOLD must be ignored.
        imem_rdata = ~instr;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_instr", instr_out, instr);
            check("stall_pc", pc_out, exp_pc);
            check("stall_addr", imem_addr, exp_pc);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_retired", retired, exp_retired);
        end
        imem_ack     = 1'b0;
        decode_ready = 1'b1;
        exp_q.push_back(exp_next);
        @(negedge clk);
        decode_ready = 1'b0;
        flags        = F_NONE;
        alu_zero     = 1'b0;
        rs_value     = $urandom();
        exp_retired  = exp_retired + 32'd1;
        check("retired", retired, exp_retired);
        check("valid_clear", {31'd0, instr_valid}, 32'd0);
        check("link_we", {31'd0, link_we}, {31'd0, f[4]});
        if (f[4]) begin
            check("link_addr", link_addr, exp_pc + 32'd4);
            @(negedge clk);
            check("link_pulse_end", {31'd0, link_we}, 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_link_we", {31'd0, link_we}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        reset = 1'b0;
        exp_q.push_back(32'h0000_0000);

        step(ADDI, F_NONE, 1'b0, 32'd0, 0, 0, 32'h0000_0004);
        step(ADDI, F_NONE, 1'b0, 32'd0, 0, 0, 32'h0000_0008);
        step(ADDI, F_NONE, 1'b0, 32'd0, 0, 0, 32'h0000_000C);
        check("retired_three", retired, 32'd3);

        step(32'h0800_0010, F_J,    1'b0, 32'd0, 0, 0, 32'h0000_0040);
        step(32'h1000_FFFE, F_BEQ,  1'b1, 32'd0, 0, 0, 32'h0000_003C);
        step(32'h0800_0010, F_J,    1'b0, 32'd0, 0, 0, 32'h0000_0040);
        step(32'h1000_FFFE, F_BEQ,  1'b0, 32'd0, 0, 0, 32'h0000_0044);
        step(32'h1400_0002, F_BNE,  1'b0, 32'd0, 0, 0, 32'h0000_0050);
        step(32'h1C20_0002, F_BGTZ, 1'b0, 32'd1, 0, 0, 32'h0000_005C);
        step(32'h1820_0002, F_BLEZ, 1'b0, 32'd5, 0, 0, 32'h0000_0060);
        step(J80,           F_J,    1'b0, 32'd0, 0, 0, 32'h0000_0080);

        step(32'h0421_0004, F_REGIMM, 1'b0, 32'h0000_0000, 0, 0, 32'h0000_0094);
        step(J80,           F_J,      1'b0, 32'd0,         0, 0, 32'h0000_0080);
        step(32'h0421_0004, F_REGIMM, 1'b0, 32'h8000_0000, 0, 0, 32'h0000_0084);
        step(J80,           F_J,      1'b0, 32'd0,         0, 0, 32'h0000_0080);
        step(32'h0420_0004, F_REGIMM, 1'b0, 32'h0000_0000, 0, 0, 32'h0000_0084);
        step(J80,           F_J,      1'b0, 32'd0,         0, 0, 32'h0000_0080);
        step(32'h0420_0004, F_REGIMM, 1'b0, 32'h8000_0000, 0, 0, 32'h0000_0094);

        step(32'h0800_0004, F_J, 1'b0, 32'd0, 0, 0, 32'h0000_0010);
        walk_pc = 32'h0000_0010;
        for (int i = 0; i < 2048; i++) begin
            step(32'h0421_7FFF, F_REGIMM, 1'b0, 32'd0, 0, 0, walk_pc + 32'h0002_0000);
            walk_pc = walk_pc + 32'h0002_0000;
        end

        step(32'h0C00_0100, F_JAL, 1'b0, 32'd0, 0, 0, 32'h1000_0400);
        step(ADDI, F_NONE, 1'b0, 32'd0, 3, 4, 32'h1000_0404);

        @(negedge clk);
        check("pre_reset_req", {31'd0, imem_req}, 32'd1);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_instr", instr_out, 32'd0);
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_addr", imem_addr, 32'd0);
        check("midrst_retired", retired, 32'd0);
        imem_ack    = 1'b0;
        reset       = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0000_0000);
        exp_retired = 32'd0;
        step(ADDI, F_NONE, 1'b0, 32'd0, 0, 0, 32'h0000_0004);
        step(ADDI, F_NONE, 1'b0, 32'd0, 1, 1, 32'h0000_0008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
